axi_wr_arbiter: RTL and testbench
=================================

# axi_wr_arbiter

Write-channel arbiter and sequencer for the AXI interconnect, sharing one slave write path between two masters (M0, M1). It grants the AW channel with round-robin priority, then holds ownership through the W burst and the B response. Ownership is released only after the B handshake. Its one-hot grants drive the AW, W and B multiplexers and demultiplexers in the interconnect; it does not carry payload.

## Interface
Parameters:
- LEN_W, 4: width of AWLEN (AXI3 burst length, beats = AWLEN+1).

Ports:
- ACLK  in  1  interconnect clock, all state on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWVALID_M0  in  1  M0 address-write request.
- AWVALID_M1  in  1  M1 address-write request.
- AWLEN_M0  in  LEN_W  M0 burst length.
- AWLEN_M1  in  LEN_W  M1 burst length.
- AWREADY_S  in  1  slave accepts AW.
- WVALID  in  1  muxed W valid from the owning master.
- WREADY  in  1  slave W ready.
- WLAST  in  1  muxed W last.
- BVALID  in  1  slave B valid.
- BREADY  in  1  muxed B ready from the owning master.
- grant_aw  out  2  one-hot AW grant {M1,M0}.
- grant_w  out  2  one-hot W ownership.
- grant_b  out  2  one-hot B routing.
- busy  out  1  high whenever state ≠ IDLE.
- wlast_err  out  1  one-cycle pulse on burst-length mismatch; only with the configuration macro.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. All outputs are registered or decoded from registers.
- Grants are one-hot or zero and never overlap.
- IDLE:
  - If either AWVALID is high, latch the winner into owner and go to ADDR.
  - Priority bit prio (0 = M0 first). Both valid → the prio master wins; one valid → that master wins.
- ADDR:
  - grant_aw = owner.
  - On AWVALID_owner & AWREADY_S: capture len = AWLEN_owner, clear beat_cnt, go to DATA.
  - A deasserted AWVALID_owner stalls in ADDR; ownership is not revoked.
- DATA:
  - grant_w = owner.
  - Each WVALID & WREADY increments beat_cnt.
  - A handshake with WLAST goes to RESP.
- RESP:
  - grant_b = owner.
  - On BVALID & BREADY: set prio to the non-owner, go to IDLE.
- Round robin: the last served master gets the lowest priority. prio changes only at the B handshake.
- Requests arriving during a transaction are ignored until IDLE.
- beat_cnt is LEN_W bits and saturates at all-ones; it never wraps.

## Timing
- Reset values: state IDLE, owner 0, prio 0, all grants 2'b00, busy 0, wlast_err 0.
- ARESET mid-transaction clears every grant immediately (asynchronous). Nothing is resumed.
- Request to grant: AWVALID sampled high in IDLE at edge n → grant_aw valid after edge n.
- Minimum transaction length, 1 beat with all readies high: IDLE→ADDR→DATA→RESP→IDLE, 4 cycles.
- Back-to-back: IDLE always occupies one cycle between transactions.
- Same-cycle events: an AW handshake and a W beat in the same cycle are not combined. The W beat is not counted, because grant_w is not yet asserted.

## Configuration
- AXI_WR_BEAT_CHECK_EN defined:
  - beat_cnt and len are implemented.
  - wlast_err pulses for one cycle on a W handshake where WLAST ≠ (beat_cnt == len).
  - A WLAST still ends DATA even when the pulse fires.
- AXI_WR_BEAT_CHECK_EN undefined:
  - No counter, no len register.
  - wlast_err tied to 0.
  - DATA exits on WLAST only.

## Structure
- Shared package axi_pkg holds:
  - wr_state_e enum (IDLE, ADDR, DATA, RESP).
  - Master index constants M0_IDX and M1_IDX.
  - Default LEN_W.
- One sub-module: rr_pick2. It is combinational: it takes the two valids and prio and returns a one-hot winner. It is reusable by the read-side arbiter.

## Test plan
- Reset: assert ARESET → all grants 00, busy 0. Release, no requests → stays IDLE.
- Both AWVALID high at the first edge, AWLEN=3, readies high:
  - grant_aw=01, then grant_w=01 for 4 beats, then grant_b=01.
  - After the B handshake the next grant is 10 (M1).
- M1 alone, AWREADY_S low 3 cycles: grant_aw=10 held 4 cycles. AWVALID_M0 raised mid-wait → no grant change.
- With macro, AWLEN=3, WLAST on beat 2 → wlast_err pulse exactly 1 cycle, FSM enters RESP.
- ARESET asserted during DATA, beat 2 → grant_w drops to 00 the same cycle. After release → IDLE with prio=0.
- Single-beat burst (AWLEN=0), all readies high → transaction completes in 4 cycles, busy high for 3.

Source files
------------

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI interconnect arbiters.
//   wr_state_e     : write-side sequencer states (IDLE, ADDR, DATA, RESP)
//   M0_IDX, M1_IDX : bit positions of each master in the one-hot grant vectors
//   AXI_LEN_W      : default AWLEN width (AXI3, beats = AWLEN + 1)
//   idx_to_onehot  : master index -> one-hot {M1,M0}
// ---------------------------------------------------------------------------
package axi_pkg;

   localparam int unsigned AXI_LEN_W = 4;

   localparam int unsigned M0_IDX = 0;
   localparam int unsigned M1_IDX = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } wr_state_e;

   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-requester round-robin pick, purely combinational. Shared by the read
// and write arbiters.
//   req_i  [1:0] : request valids {M1,M0}
//   prio_i       : favoured master when both request (0 = M0, 1 = M1)
//   gnt_o  [1:0] : one-hot winner, or 2'b00 when nobody requests
// ---------------------------------------------------------------------------
module rr_pick2
   import axi_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       prio_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o[M0_IDX] = 1'b1;
         2'b10:   gnt_o[M1_IDX] = 1'b1;
         2'b11:   gnt_o = prio_i ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
// Write-channel arbiter/sequencer sharing one slave write path between two
// masters. Grants AW round-robin, then holds ownership through the W burst
// and the B response; ownership is dropped only after the B handshake.
// Carries no payload: its one-hot grants steer the interconnect muxes.
//
// Ports
//   ACLK, ARESET            : clock, asynchronous active-high reset
//   AWVALID_M0/M1           : address-write requests
//   AWLEN_M0/M1 [LEN_W-1:0] : burst lengths (beats = AWLEN + 1)
//   AWREADY_S               : slave AW ready
//   WVALID, WREADY, WLAST   : muxed W handshake from the owner / slave
//   BVALID, BREADY          : slave B valid, muxed B ready from the owner
//   grant_aw/w/b [1:0]      : one-hot {M1,M0} grants per channel phase
//   busy                    : high whenever the sequencer is not idle
//   wlast_err               : one-cycle pulse on a WLAST / burst length mismatch
//
// Build option
//   AXI_WR_BEAT_CHECK_EN : adds the beat counter and len register that drive
//                          wlast_err. Without it wlast_err is tied low and DATA
//                          ends on the WLAST handshake alone.
// ---------------------------------------------------------------------------
module axi_wr_arbiter
   import axi_pkg::*;
#(
   parameter int unsigned LEN_W = AXI_LEN_W
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             AWVALID_M0,
   input  logic             AWVALID_M1,
   input  logic [LEN_W-1:0] AWLEN_M0,
   input  logic [LEN_W-1:0] AWLEN_M1,
   input  logic             AWREADY_S,
   input  logic             WVALID,
   input  logic             WREADY,
   input  logic             WLAST,
   input  logic             BVALID,
   input  logic             BREADY,
   output logic [1:0]       grant_aw,
   output logic [1:0]       grant_w,
   output logic [1:0]       grant_b,
   output logic             busy,
   output logic             wlast_err
);

   wr_state_e state_q, state_d;
   logic      owner_q, owner_d;   // 0 = M0, 1 = M1
   logic      prio_q,  prio_d;    // master favoured on a tie

   logic [1:0] pick;
   logic       aw_own_valid;
   logic       aw_hs;
   logic       w_hs;
   logic       b_hs;
   logic [1:0] owner_oh;

   rr_pick2 u_rr_pick2 (
      .req_i  ({AWVALID_M1, AWVALID_M0}),
      .prio_i (prio_q),
      .gnt_o  (pick)
   );

   assign aw_own_valid = owner_q ? AWVALID_M1 : AWVALID_M0;
   assign aw_hs        = aw_own_valid & AWREADY_S;
   assign w_hs         = WVALID & WREADY;
   assign b_hs         = BVALID & BREADY;

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      unique case (state_q)
         IDLE: begin
            if (|pick) begin
               owner_d = pick[M1_IDX];
               state_d = ADDR;
            end
         end
         ADDR: begin
            // A dropped AWVALID only stalls; the owner keeps the slot.
            if (aw_hs) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (w_hs && WLAST) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (b_hs) begin
               prio_d  = ~owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
      end
   end

   // ------------------------------------------------------------------------
   // Burst length check
   // ------------------------------------------------------------------------
`ifdef AXI_WR_BEAT_CHECK_EN
   logic [LEN_W-1:0] len_q,  len_d;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic             err_q,  err_d;

   always_comb begin
      len_d  = len_q;
      beat_d = beat_q;
      err_d  = 1'b0;
      if (state_q == ADDR && aw_hs) begin
         len_d  = owner_q ? AWLEN_M1 : AWLEN_M0;
         beat_d = '0;
      end
      // Only beats seen while W is granted count; a W handshake coinciding
      // with the AW handshake belongs to nobody yet.
      if (state_q == DATA && w_hs) begin
         if (beat_q != '1) begin
            beat_d = beat_q + LEN_W'(1);
         end
         // beat_q counts beats before this one, so the last beat sees len.
         err_d = WLAST != (beat_q == len_q);
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         len_q  <= '0;
         beat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         len_q  <= len_d;
         beat_q <= beat_d;
         err_q  <= err_d;
      end
   end

   assign wlast_err = err_q;
`else
   logic unused_awlen;
   assign unused_awlen = ^{AWLEN_M0, AWLEN_M1};
   assign wlast_err    = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Outputs, decoded from state and owner registers only
   // ------------------------------------------------------------------------
   assign owner_oh = idx_to_onehot(owner_q);
   assign grant_aw = (state_q == ADDR) ? owner_oh : 2'b00;
   assign grant_w  = (state_q == DATA) ? owner_oh : 2'b00;
   assign grant_b  = (state_q == RESP) ? owner_oh : 2'b00;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_arbiter
// Directed bench for axi_wr_arbiter. Observed vector per cycle:
//   obs = {grant_aw[1:0], grant_w[1:0], grant_b[1:0], busy, wlast_err}
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_axi_wr_arbiter;

   localparam int unsigned LEN_W = 4;

`ifdef AXI_WR_BEAT_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic             ACLK;
   logic             ARESET;
   logic             AWVALID_M0;
   logic             AWVALID_M1;
   logic [LEN_W-1:0] AWLEN_M0;
   logic [LEN_W-1:0] AWLEN_M1;
   logic             AWREADY_S;
   logic             WVALID;
   logic             WREADY;
   logic             WLAST;
   logic             BVALID;
   logic             BREADY;
   logic [1:0]       grant_aw;
   logic [1:0]       grant_w;
   logic [1:0]       grant_b;
   logic             busy;
   logic             wlast_err;

   logic [7:0]       obs;
   int               vec;
   int               errs;

   axi_wr_arbiter #(
      .LEN_W (LEN_W)
   ) dut (
      .ACLK       (ACLK),
      .ARESET     (ARESET),
      .AWVALID_M0 (AWVALID_M0),
      .AWVALID_M1 (AWVALID_M1),
      .AWLEN_M0   (AWLEN_M0),
      .AWLEN_M1   (AWLEN_M1),
      .AWREADY_S  (AWREADY_S),
      .WVALID     (WVALID),
      .WREADY     (WREADY),
      .WLAST      (WLAST),
      .BVALID     (BVALID),
      .BREADY     (BREADY),
      .grant_aw   (grant_aw),
      .grant_w    (grant_w),
      .grant_b    (grant_b),
      .busy       (busy),
      .wlast_err  (wlast_err)
   );

   assign obs = {grant_aw, grant_w, grant_b, busy, wlast_err};

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic idle_inputs();
      AWVALID_M0 = 1'b0;
      AWVALID_M1 = 1'b0;
      AWLEN_M0   = '0;
      AWLEN_M1   = '0;
      AWREADY_S  = 1'b0;
      WVALID     = 1'b0;
      WREADY     = 1'b0;
      WLAST      = 1'b0;
      BVALID     = 1'b0;
      BREADY     = 1'b0;
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      idle_inputs();
      step();
      ARESET = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      idle_inputs();
      step();
      vec++;
      if (obs !== 8'b00_00_00_0_0) begin
         errs++;
         $display("FAIL reset_held: got %b want %b", obs, 8'b00_00_00_0_0);
      end
      AWVALID_M0 = 1'b1;
      step();
      vec++;
      if (obs !== 8'b00_00_00_0_0) begin
         errs++;
         $display("FAIL reset_req_ignored: got %b want %b", obs, 8'b00_00_00_0_0);
      end
      AWVALID_M0 = 1'b0;
      ARESET     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         vec++;
         if (obs !== 8'b00_00_00_0_0) begin
            errs++;
            $display("FAIL reset_idle[%0d]: got %b want %b", i, obs, 8'b00_00_00_0_0);
         end
      end
   endtask

   // Both request at once with prio 0: M0 wins, 4-beat burst, then M1 next.
   task automatic test_both_rr();
      logic [7:0] exp;
      AWVALID_M0 = 1'b1;
      AWVALID_M1 = 1'b1;
      AWLEN_M0   = 4'd3;
      AWLEN_M1   = 4'd3;
      AWREADY_S  = 1'b1;
      WVALID     = 1'b1;
      WREADY     = 1'b1;
      WLAST      = 1'b0;
      BVALID     = 1'b1;
      BREADY     = 1'b1;
      step();
      vec++;
      if (obs !== 8'b01_00_00_1_0) begin
         errs++;
         $display("FAIL both_aw_m0: got %b want %b", obs, 8'b01_00_00_1_0);
      end
      step();
      vec++;
      if (obs !== 8'b00_01_00_1_0) begin
         errs++;
         $display("FAIL both_w_enter: got %b want %b", obs, 8'b00_01_00_1_0);
      end
      AWVALID_M0 = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         WLAST = (b == 4);
         step();
         exp = (b < 4) ? 8'b00_01_00_1_0 : 8'b00_00_01_1_0;
         vec++;
         if (obs !== exp) begin
            errs++;
            $display("FAIL both_beat%0d: got %b want %b", b, obs, exp);
         end
      end
      WLAST      = 1'b0;
      WVALID     = 1'b0;
      AWVALID_M0 = 1'b1;
      step();
      vec++;
      if (obs !== 8'b00_00_00_0_0) begin
         errs++;
         $display("FAIL both_idle_gap: got %b want %b", obs, 8'b00_00_00_0_0);
      end
      step();
      vec++;
      if (obs !== 8'b10_00_00_1_0) begin
         errs++;
         $display("FAIL both_rr_m1: got %b want %b", obs, 8'b10_00_00_1_0);
      end
   endtask

   // M1 alone, AWREADY_S low for 3 edges; M0 raised mid-wait changes nothing.
   task automatic test_aw_stall();
      do_reset();
      AWVALID_M1 = 1'b1;
      AWLEN_M1   = 4'd0;
      WREADY     = 1'b1;
      WLAST      = 1'b1;
      BREADY     = 1'b1;
      step();
      vec++;
      if (obs !== 8'b10_00_00_1_0) begin
         errs++;
         $display("FAIL stall_grant: got %b want %b", obs, 8'b10_00_00_1_0);
      end
      AWVALID_M0 = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         step();
         vec++;
         if (obs !== 8'b10_00_00_1_0) begin
            errs++;
            $display("FAIL stall_hold%0d: got %b want %b", k, obs, 8'b10_00_00_1_0);
         end
      end
      AWREADY_S = 1'b1;
      step();
      vec++;
      if (obs !== 8'b00_10_00_1_0) begin
         errs++;
         $display("FAIL stall_w: got %b want %b", obs, 8'b00_10_00_1_0);
      end
      AWVALID_M1 = 1'b0;
      WVALID     = 1'b1;
      step();
      vec++;
      if (obs !== 8'b00_00_10_1_0) begin
         errs++;
         $display("FAIL stall_b: got %b want %b", obs, 8'b00_00_10_1_0);
      end
      WVALID = 1'b0;
      BVALID = 1'b1;
      step();
      vec++;
      if (obs !== 8'b00_00_00_0_0) begin
         errs++;
         $display("FAIL stall_idle: got %b want %b", obs, 8'b00_00_00_0_0);
      end
      BVALID = 1'b0;
      step();
      vec++;
      if (obs !== 8'b01_00_00_1_0) begin
         errs++;
         $display("FAIL stall_m0_next: got %b want %b", obs, 8'b01_00_00_1_0);
      end
   endtask

   // AWLEN=0, all readies high: 4 cycles, busy for 3. W/WLAST high during ADDR.
   task automatic test_single_beat();
      logic [7:0] exp_seq [4];
      int         busy_cycles;
      exp_seq[0] = 8'b01_00_00_1_0;
      exp_seq[1] = 8'b00_01_00_1_0;
      exp_seq[2] = 8'b00_00_01_1_0;
      exp_seq[3] = 8'b00_00_00_0_0;
      busy_cycles = 0;
      do_reset();
      AWVALID_M0 = 1'b1;
      AWLEN_M0   = 4'd0;
      AWREADY_S  = 1'b1;
      WVALID     = 1'b1;
      WREADY     = 1'b1;
      WLAST      = 1'b1;
      BVALID     = 1'b1;
      BREADY     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         vec++;
         if (obs !== exp_seq[i]) begin
            errs++;
            $display("FAIL single_cyc%0d: got %b want %b", i, obs, exp_seq[i]);
         end
         busy_cycles += int'(busy);
         if (i == 1) AWVALID_M0 = 1'b0;
      end
      vec++;
      if (busy_cycles != 3) begin
         errs++;
         $display("FAIL single_busy_cycles: got %0d want %0d", busy_cycles, 3);
      end
      idle_inputs();
   endtask

   // Entered with prio=1 (M0 just served). Reset mid-DATA must clear prio too.
   task automatic test_reset_mid_data();
      AWVALID_M1 = 1'b1;
      AWLEN_M1   = 4'd3;
      AWREADY_S  = 1'b1;
      WVALID     = 1'b1;
      WREADY     = 1'b1;
      WLAST      = 1'b0;
      BREADY     = 1'b1;
      step();
      vec++;
      if (obs !== 8'b10_00_00_1_0) begin
         errs++;
         $display("FAIL rst_mid_aw: got %b want %b", obs, 8'b10_00_00_1_0);
      end
      step();
      AWVALID_M1 = 1'b0;
      step();
      step();
      vec++;
      if (obs !== 8'b00_10_00_1_0) begin
         errs++;
         $display("FAIL rst_mid_beat2: got %b want %b", obs, 8'b00_10_00_1_0);
      end
      #2;
      ARESET = 1'b1;
      #1;
      vec++;
      if (obs !== 8'b00_00_00_0_0) begin
         errs++;
         $display("FAIL rst_mid_async: got %b want %b", obs, 8'b00_00_00_0_0);
      end
      #2;
      ARESET = 1'b0;
      idle_inputs();
      AWVALID_M0 = 1'b1;
      AWVALID_M1 = 1'b1;
      step();
      vec++;
      if (obs !== 8'b01_00_00_1_0) begin
         errs++;
         $display("FAIL rst_mid_prio0: got %b want %b", obs, 8'b01_00_00_1_0);
      end
      idle_inputs();
   endtask

   // AWLEN=3 but WLAST on the 2nd beat: DATA still ends, pulse lasts one cycle.
   task automatic test_wlast_err();
      do_reset();
      AWVALID_M0 = 1'b1;
      AWLEN_M0   = 4'd3;
      AWREADY_S  = 1'b1;
      WVALID     = 1'b1;
      WREADY     = 1'b1;
      BREADY     = 1'b1;
      step();
      step();
      AWVALID_M0 = 1'b0;
      step();
      vec++;
      if (obs !== 8'b00_01_00_1_0) begin
         errs++;
         $display("FAIL werr_beat1: got %b want %b", obs, 8'b00_01_00_1_0);
      end
      WLAST = 1'b1;
      step();
      vec++;
      if (obs !== {6'b00_00_01, 1'b1, ERR_EXP}) begin
         errs++;
         $display("FAIL werr_pulse: got %b want %b", obs, {6'b00_00_01, 1'b1, ERR_EXP});
      end
      WLAST  = 1'b0;
      WVALID = 1'b0;
      step();
      vec++;
      if (obs !== 8'b00_00_01_1_0) begin
         errs++;
         $display("FAIL werr_pulse_end: got %b want %b", obs, 8'b00_00_01_1_0);
      end
      BVALID = 1'b1;
      step();
      idle_inputs();
   endtask

   // AWLEN=1 with WVALID held through the AW handshake: that beat is not
   // counted, so a WLAST on the 2nd granted beat is correct.
   task automatic test_same_cycle();
      do_reset();
      AWVALID_M0 = 1'b1;
      AWLEN_M0   = 4'd1;
      AWREADY_S  = 1'b1;
      WVALID     = 1'b1;
      WREADY     = 1'b1;
      BREADY     = 1'b1;
      step();
      step();
      AWVALID_M0 = 1'b0;
      step();
      WLAST = 1'b1;
      step();
      vec++;
      if (obs !== 8'b00_00_01_1_0) begin
         errs++;
         $display("FAIL same_cycle_no_err: got %b want %b", obs, 8'b00_00_01_1_0);
      end
      idle_inputs();
      BVALID = 1'b1;
      BREADY = 1'b1;
      step();
      vec++;
      if (obs !== 8'b00_00_00_0_0) begin
         errs++;
         $display("FAIL same_cycle_idle: got %b want %b", obs, 8'b00_00_00_0_0);
      end
      idle_inputs();
   endtask

   initial begin
      vec  = 0;
      errs = 0;
      test_reset();
      test_both_rr();
      test_aw_stall();
      test_single_beat();
      test_reset_mid_data();
      test_wlast_err();
      test_same_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
